adc_ramp_sequencer: RTL and testbench
=====================================

# adc_ramp_sequencer

Sequencer for the ramp-compare ADC. It runs fixed-length ramp periods for the external ramp generator. In each period it captures the coarse cycle count and the fine TDC code of the first comparator edge. It averages 2^AVG_LOG2 period samples and hands each averaged result downstream over a valid/ready handshake. It sits between the two fine TDC encoders and the sample consumer (FIFO or host interface), in the 48 MHz `clock` domain.

## Interface
- FINE_BITS, 7, width of the fine TDC code
- COARSE_BITS, 4, coarse counter width; ramp period = 2^COARSE_BITS clocks
- AVG_LOG2, 2, log2 of the number of samples averaged per result (0 = no averaging)
- clock  in  1  conversion clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run conversions while high
- cmp_edge  in  1  one-cycle pulse, comparator edge detected this cycle (already synchronous)
- fine_value  in  FINE_BITS  fine TDC code, valid in the cmp_edge cycle
- ramp_start  out  1  one-cycle pulse at the first cycle of each ramp period
- sample  out  COARSE_BITS+FINE_BITS  averaged result {coarse, fine}
- sample_valid  out  1  sample holds an unconsumed result
- sample_ready  in  1  consumer accepts sample when valid && ready
- overrun  out  1  sticky: a result was dropped because sample_valid was still high
- clear  in  1  synchronous clear of overrun (and miss_count)
- miss_count  out  8  periods with no comparator edge (see Configuration)

## Operation
- States: IDLE, RAMP, HOLD.
- IDLE: coarse counter = 0. When enable = 1, go to RAMP and pulse ramp_start in the same cycle. The coarse counter is 0 in that cycle.
- The coarse counter increments every cycle in RAMP and HOLD. It wraps from 2^COARSE_BITS-1 to 0. Every wrap-to-0 cycle pulses ramp_start and starts a new period in RAMP.
- RAMP: on cmp_edge, latch raw = {coarse, fine_value} and go to HOLD. An edge in a ramp_start cycle belongs to the new period, with coarse = 0.
- HOLD: further cmp_edge pulses are ignored until the period ends.
- Period end is the cycle with coarse = 2^COARSE_BITS-1:
  - If an edge was captured, add raw to the accumulator. If the edge arrives in this end cycle, it is captured and used.
  - If no edge was captured, add all-ones (saturated raw) and count a miss.
  - Increment the sample counter.
- Accumulator width is COARSE_BITS+FINE_BITS+AVG_LOG2, unsigned, and cannot overflow.
- After 2^AVG_LOG2 periods, result = accumulator >> AVG_LOG2 (truncating). The accumulator and sample counter then clear.
- Output register:
  - If sample_valid = 0, or valid && ready in the same cycle, load result and set sample_valid = 1.
  - Otherwise drop the result, keep the old sample, and set overrun.
- sample_valid clears on valid && ready when no new result is loading that cycle.
- enable falling mid-period: go to IDLE next cycle and discard the partial accumulator, sample counter and captured raw. sample, sample_valid and overrun are held.
- clear takes priority over setting overrun in the same cycle.

## Timing
- Reset values:
  - state = IDLE, coarse = 0, accumulator = 0.
  - sample = 0, sample_valid = 0, overrun = 0, miss_count = 0, ramp_start = 0.
- ramp_start is registered and asserts in the cycle coarse = 0.
- From enable rising: ramp_start in the next cycle. The result of the first 2^AVG_LOG2 periods sets sample_valid 1 cycle after the end cycle of the last period.
- Sample rate: one result every 2^(COARSE_BITS+AVG_LOG2) clocks while enabled.
- Back-to-back results: no bubble between periods or between averaging windows.
- Handshake: sample is stable while sample_valid = 1 and ready = 0.

## Configuration
- ADC_SEQ_MISS_CNT_EN defined:
  - miss_count is an 8-bit saturating counter (stops at 255).
  - It increments at each period end with no captured edge.
  - clear resets it to 0.
- Macro undefined: miss_count is driven constant 0 and the counter logic is not built. All other behaviour is identical.

## Test plan
All scenarios use defaults (FINE_BITS=7, COARSE_BITS=4, AVG_LOG2=2).
- Reset released, enable=1: ramp_start pulses every 16 cycles; sample_valid stays 0 until the 4th period end plus 1 cycle.
- Edge at coarse=5, fine=0x20 in all 4 periods, ready=1: sample = 0x2A0 and sample_valid high 1 cycle.
- Edges {coarse,fine} = 0x100, 0x101, 0x102, 0x104: sample = 0x101 (sum 0x407 >> 2).
- Second edge in the same period with a different fine code: ignored, sample unchanged from the single-edge value. Edge in the ramp_start cycle: coarse 0 captured.
- No edges for 4 periods: sample = 0x7FF. With the macro defined, miss_count = 4; clear makes it 0.
- ready=0 over two results: first sample held, overrun=1. Then enable=0 mid-period: partial window discarded and the next result needs 4 full new periods.

Source files
------------

// File: rtl/adc_ramp_sequencer.sv
// Ramp-compare ADC sequencer: fixed ramp periods, first-edge capture, 2^AVG_LOG2 averaging, valid/ready output.
// Optional miss counter is built only when ADC_SEQ_MISS_CNT_EN is defined.
module adc_ramp_sequencer #(
   parameter int FINE_BITS   = 7,
   parameter int COARSE_BITS = 4,
   parameter int AVG_LOG2    = 2
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             enable,
   input  logic                             cmp_edge,
   input  logic [FINE_BITS-1:0]             fine_value,
   output logic                             ramp_start,
   output logic [COARSE_BITS+FINE_BITS-1:0] sample,
   output logic                             sample_valid,
   input  logic                             sample_ready,
   output logic                             overrun,
   input  logic                             clear,
   output logic [7:0]                       miss_count
);
   localparam int RAW_BITS = COARSE_BITS + FINE_BITS;
   localparam int ACC_BITS = RAW_BITS + AVG_LOG2;
   localparam int CNT_BITS = AVG_LOG2 + 1;
   localparam logic [COARSE_BITS-1:0] COARSE_LAST = {COARSE_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0]    CNT_LAST    = CNT_BITS'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, HOLD = 2'd2} state_t;

   state_t                 state_r, state_s;
   logic [COARSE_BITS-1:0] coarse_r;
   logic [RAW_BITS-1:0]    raw_r;
   logic [ACC_BITS-1:0]    acc_r;
   logic [CNT_BITS-1:0]    cnt_r;
   logic                   in_run_s, period_end_s, edge_now_s, hit_s, last_s, ramp_start_s;
   logic [RAW_BITS-1:0]    add_s;
   logic [ACC_BITS-1:0]    acc_sum_s;
   logic [RAW_BITS-1:0]    result_s;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; a period end always restarts in RAMP
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) state_s = RAMP;
            else        state_s = IDLE;
         end
         RAMP: begin
            if (!enable)                   state_s = IDLE;
            else if (coarse_r == COARSE_LAST) state_s = RAMP;
            else if (cmp_edge)             state_s = HOLD;
            else                           state_s = RAMP;
         end
         HOLD: begin
            if (!enable)                   state_s = IDLE;
            else if (coarse_r == COARSE_LAST) state_s = RAMP;
            else                           state_s = HOLD;
         end
         default: state_s = IDLE;
      endcase
   end

   // Datapath decode: captured value, accumulation and window completion
   always_comb begin
      in_run_s     = (state_r != IDLE) && enable;
      period_end_s = in_run_s && (coarse_r == COARSE_LAST);
      edge_now_s   = (state_r == RAMP) && cmp_edge;
      hit_s        = (state_r == HOLD) || edge_now_s;
      if (state_r == HOLD) begin
         add_s = raw_r;
      end else if (hit_s) begin
         add_s = {coarse_r, fine_value};
      end else begin
         add_s = {RAW_BITS{1'b1}};
      end
      acc_sum_s    = acc_r + ACC_BITS'(add_s);
      last_s       = period_end_s && (cnt_r == CNT_LAST);
      result_s     = acc_sum_s[ACC_BITS-1:AVG_LOG2];
      ramp_start_s = enable && ((state_r == IDLE) || (coarse_r == COARSE_LAST));
   end

   // Coarse counter, raw capture and averaging accumulator
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         coarse_r <= {COARSE_BITS{1'b0}};
         raw_r    <= {RAW_BITS{1'b0}};
         acc_r    <= {ACC_BITS{1'b0}};
         cnt_r    <= {CNT_BITS{1'b0}};
      end else if (!in_run_s) begin
         coarse_r <= {COARSE_BITS{1'b0}};
         raw_r    <= {RAW_BITS{1'b0}};
         acc_r    <= {ACC_BITS{1'b0}};
         cnt_r    <= {CNT_BITS{1'b0}};
      end else begin
         coarse_r <= coarse_r + {{(COARSE_BITS-1){1'b0}}, 1'b1};
         if (edge_now_s) raw_r <= {coarse_r, fine_value};
         else            raw_r <= raw_r;
         if (last_s) begin
            acc_r <= {ACC_BITS{1'b0}};
            cnt_r <= {CNT_BITS{1'b0}};
         end else if (period_end_s) begin
            acc_r <= acc_sum_s;
            cnt_r <= cnt_r + CNT_BITS'(1);
         end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
         end
      end
   end

   // Output register: a result arriving while the old one is unconsumed is dropped and flagged
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sample       <= {RAW_BITS{1'b0}};
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         ramp_start   <= 1'b0;
      end else begin
         ramp_start <= ramp_start_s;
         if (last_s && (!sample_valid || sample_ready)) begin
            sample       <= result_s;
            sample_valid <= 1'b1;
         end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
         end else begin
            sample_valid <= sample_valid;
         end
         if (clear)                                      overrun <= 1'b0;
         else if (last_s && sample_valid && !sample_ready) overrun <= 1'b1;
         else                                            overrun <= overrun;
      end
   end

`ifdef ADC_SEQ_MISS_CNT_EN
   logic [7:0] miss_r;

   // Saturating count of periods that ended without a comparator edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         miss_r <= 8'd0;
      end else if (clear) begin
         miss_r <= 8'd0;
      end else if (period_end_s && !hit_s && (miss_r != 8'hFF)) begin
         miss_r <= miss_r + 8'd1;
      end else begin
         miss_r <= miss_r;
      end
   end

   assign miss_count = miss_r;
`else
   assign miss_count = 8'd0;
`endif

endmodule

// File: tb/tb_adc_ramp_sequencer.sv
// Directed bench for adc_ramp_sequencer: expected averages are queued by the stimulus and
// compared by a monitor at every accepted handshake.
module tb_adc_ramp_sequencer;
   logic        clock = 1'b0;
   logic        reset, enable, cmp_edge, sample_ready, clear;
   logic [6:0]  fine_value;
   logic        ramp_start, sample_valid, overrun;
   logic [10:0] sample;
   logic [7:0]  miss_count;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [10:0] exp_q[$];

`ifdef ADC_SEQ_MISS_CNT_EN
   localparam int EXP_MISS = 4;
`else
   localparam int EXP_MISS = 0;
`endif

   adc_ramp_sequencer dut (
      .clock(clock), .reset(reset), .enable(enable), .cmp_edge(cmp_edge),
      .fine_value(fine_value), .ramp_start(ramp_start), .sample(sample),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun),
      .clear(clear), .miss_count(miss_count)
   );

   always #10 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One 16-cycle ramp period, entered at the coarse=0 cycle; c1/c2 < 0 means no edge
   task automatic do_period(input int c1, input int f1, input int c2, input int f2,
                            input int exp_v0, input int exp_v1, input bit clr);
      bit rs_bad;
      rs_bad = 1'b0;
      for (int k = 0; k < 16; k++) begin
         cmp_edge   = (k == c1) || (k == c2);
         fine_value = (k == c2) ? 7'(f2) : 7'(f1);
         clear      = clr && (k == 0);
         if (k == 0) chk("ramp_start_at_coarse0", int'(ramp_start), 1);
         else if (ramp_start !== 1'b0) rs_bad = 1'b1;
         if (k == 0 && exp_v0 >= 0) chk("valid_at_period_start", int'(sample_valid), exp_v0);
         if (k == 1 && exp_v1 >= 0) chk("valid_second_cycle", int'(sample_valid), exp_v1);
         step();
      end
      cmp_edge = 1'b0;
      clear    = 1'b0;
      chk("ramp_start_quiet_mid_period", int'(rs_bad), 0);
   endtask

   // Scoreboard monitor: every accepted sample must match the oldest queued expectation
   always @(negedge clock) begin
      if (!reset && sample_valid && sample_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_sample: got 0x%0h, nothing expected", sample);
         end else begin
            chk("sample", int'(sample), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b0; cmp_edge = 1'b0; fine_value = 7'd0;
      sample_ready = 1'b1; clear = 1'b0;
      repeat (3) step();
      chk("rst_sample", int'(sample), 0);
      chk("rst_valid", int'(sample_valid), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_miss", int'(miss_count), 0);
      chk("rst_ramp_start", int'(ramp_start), 0);
      reset = 1'b0;
      repeat (2) step();
      chk("idle_no_ramp_start", int'(ramp_start), 0);
      enable = 1'b1;
      step();

      // Window 1: edge at coarse 5, fine 0x20 -> 0x2A0
      exp_q.push_back(11'h2A0);
      for (int i = 0; i < 4; i++) do_period(5, 'h20, -1, 0, 0, -1, 1'b0);
      // Window 2: 0x100,0x101,0x102,0x104 -> 0x101
      exp_q.push_back(11'h101);
      do_period(2, 0, -1, 0, 1, 0, 1'b0);
      do_period(2, 1, -1, 0, 0, -1, 1'b0);
      do_period(2, 2, -1, 0, 0, -1, 1'b0);
      do_period(2, 4, -1, 0, 0, -1, 1'b0);
      // Window 3: second edge per period ignored -> 0x190
      exp_q.push_back(11'h190);
      do_period(3, 'h10, 7, 'h55, 1, 0, 1'b0);
      for (int i = 0; i < 3; i++) do_period(3, 'h10, 7, 'h55, 0, -1, 1'b0);
      // Window 4: edges in ramp_start and end cycles: 0x033+0x035+0x781+0x783 -> 0x3DB
      exp_q.push_back(11'h3DB);
      do_period(0, 'h33, -1, 0, 1, 0, 1'b0);
      do_period(0, 'h35, -1, 0, 0, -1, 1'b0);
      do_period(15, 'h01, -1, 0, 0, -1, 1'b0);
      do_period(15, 'h03, -1, 0, 0, -1, 1'b0);
      // Window 5: no edges -> saturated 0x7FF
      exp_q.push_back(11'h7FF);
      do_period(-1, 0, -1, 0, 1, 0, 1'b0);
      for (int i = 0; i < 3; i++) do_period(-1, 0, -1, 0, 0, -1, 1'b0);
      chk("miss_count_after_misses", int'(miss_count), EXP_MISS);

      // Window 6 -> 0x080, left unconsumed; clear applied in its second period
      exp_q.push_back(11'h080);
      do_period(1, 0, -1, 0, 1, 0, 1'b0);
      sample_ready = 1'b0;
      do_period(1, 0, -1, 0, 0, -1, 1'b1);
      chk("miss_count_cleared", int'(miss_count), 0);
      do_period(1, 0, -1, 0, 0, -1, 1'b0);
      do_period(1, 0, -1, 0, 0, -1, 1'b0);
      // Window 7 -> 0x084 is dropped because 0x080 is still waiting
      do_period(1, 4, -1, 0, 1, 1, 1'b0);
      for (int i = 0; i < 3; i++) do_period(1, 4, -1, 0, 1, -1, 1'b0);
      chk("overrun_set", int'(overrun), 1);
      chk("sample_held_on_drop", int'(sample), 'h080);

      // Partial window (2 full periods + 5 cycles) then enable falls
      do_period(9, 0, -1, 0, 1, -1, 1'b0);
      do_period(9, 0, -1, 0, 1, -1, 1'b0);
      repeat (5) step();
      enable = 1'b0;
      repeat (6) step();
      chk("idle_after_disable", int'(ramp_start), 0);
      chk("valid_held_idle", int'(sample_valid), 1);
      chk("overrun_held_idle", int'(overrun), 1);
      chk("sample_held_idle", int'(sample), 'h080);
      sample_ready = 1'b1;
      step();
      chk("valid_cleared_by_ready", int'(sample_valid), 0);

      // Restart: a result only after 4 fresh periods -> 0x308
      exp_q.push_back(11'h308);
      enable = 1'b1;
      step();
      for (int i = 0; i < 4; i++) do_period(6, 8, -1, 0, 0, -1, 1'b0);
      do_period(6, 8, -1, 0, 1, 0, 1'b0);
      enable = 1'b0;
      repeat (3) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("overrun_cleared", int'(overrun), 0);
      repeat (3) step();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
